mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: XLEN, 32, address/data width.
REQ-002 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level, held until if_done.
- if_addr  in  XLEN  fetch address.
- if_rdata  out  XLEN  fetched word, valid with if_done.
- if_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request, level, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_be  in  4  store byte enables.
- d_rdata  out  XLEN  load word, valid with d_done.
- d_done  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  XLEN  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, one cycle.

Function
REQ-003 FSM states SHALL be IDLE, GNT_I, GNT_D and RESP.
REQ-004 IDLE, arbitration:
- d_req only -> GNT_D.
- if_req only -> GNT_I.
- both -> per REQ-012.
- neither -> stay in IDLE.
REQ-005 On leaving IDLE, the winner's address, we, wdata and be SHALL be latched into registers driving mem_*.
- Fetch: mem_we=0, mem_be=4'b1111, mem_wdata=0.
REQ-006 mem_req SHALL be 1 exactly while in GNT_I/GNT_D; mem_* SHALL stay stable until mem_ready.
REQ-007 In GNT_x with mem_ready=1:
- capture mem_rdata into the owner's rdata register;
- go to RESP, where the owner's done=1 for exactly one cycle.
REQ-008 RESP SHALL always go to IDLE and SHALL grant nothing, so a request still high in the done cycle is not serviced twice.
REQ-009 Minimum latency from req to done SHALL be 3 cycles with zero-wait memory (mem_ready in first grant cycle); each extra wait cycle adds one.
REQ-010 if_rdata/d_rdata SHALL hold their last captured value until the next completion for that port; stores SHALL also update d_rdata with mem_rdata.
REQ-011 mem_ready outside GNT_I/GNT_D SHALL be ignored; a requester dropping req mid-grant SHALL NOT abort the memory transaction.

Reset
REQ-012 (see Configuration for both-request arbitration.)
REQ-013 rst=1 SHALL immediately force:
- state IDLE;
- all outputs 0 (mem_req, if_done, d_done, rdata and mem_* registers);
- rr_last = 0 (last grant = fetch).
REQ-014 Reset mid-transaction SHALL abandon it without a done pulse; the memory tolerates a dropped mem_req.

Configuration
REQ-015 Macro ARB_ROUND_ROBIN_EN governs REQ-012:
- Undefined: data always wins when both request (fixed priority, MEM stage over fetch).
- Defined: a 1-bit rr_last register records the last granted port; when both request, the port not in rr_last wins; rr_last updates on every grant.

Structure
REQ-016 Shared package riscv_pkg SHALL hold XLEN default and the arbiter state enum (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2, RESP=2'd3).
REQ-017 Single module; no sub-module is warranted.

Verification
REQ-018 Fetch only: if_addr=0x100, mem_rdata=0x00500093, zero-wait -> mem_req 1 cycle, if_done 3 cycles after if_req, if_rdata=0x00500093.
REQ-019 Store with 2 wait states: d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1, mem_be=4'b0011, mem_* stable 3 cycles, d_done at cycle 5.
REQ-020 Simultaneous if_req and d_req held continuously, macro undefined -> grant order D,D,D while d_req stays high; macro defined -> grants alternate D,I,D,I.
REQ-021 Request held high through its done cycle -> no grant in RESP; exactly one new transaction starts from IDLE after.
REQ-022 rst pulsed during GNT_D with mem_ready low -> mem_req=0 on the same cycle, no d_done, state IDLE; later mem_ready=1 is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter: default bus width, FSM state encoding
// and the encoding used to record which port owns the memory.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic       OWNER_I = 1'b0;
    localparam logic       OWNER_D = 1'b1;
    localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and data access.
// Build macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data-first priority.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch the winner onto mem_*
// GNT_I | fetch owns the memory, mem_req held until mem_ready
// GNT_D | data port owns the memory, mem_req held until mem_ready
// RESP  | one-cycle done pulse to the owner, nothing is granted
module mem_arbiter #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_done,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready
);
    import riscv_pkg::*;

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            pick_d, pick_i, grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic            rr_last_q, rr_last_d;
`endif

    // Contention rule: only consulted in IDLE, RESP never grants.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = d_req && (!if_req || (rr_last_q == OWNER_I));
`else
        pick_d = d_req;
`endif
        pick_i = if_req && !pick_d;
        grant  = (state_q == IDLE) && (pick_d || pick_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = GNT_D;
                end else if (pick_i) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state_q == GNT_I) || (state_q == GNT_D);
        if_done = (state_q == RESP) && (owner_q == OWNER_I);
        d_done  = (state_q == RESP) && (owner_q == OWNER_D);
    end

    // Request fields are latched once at grant so mem_* cannot move while the memory works.
    always_comb begin
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        if (grant && pick_d) begin
            owner_d     = OWNER_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
        end else if (grant) begin
            owner_d     = OWNER_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = BE_ALL;
        end

        if ((state_q == GNT_I) && mem_ready) begin
            if_rdata_d = mem_rdata;
        end
        if ((state_q == GNT_D) && mem_ready) begin
            d_rdata_d = mem_rdata;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (grant) begin
            rr_last_d = owner_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= OWNER_I;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWNER_I;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
